line_buffer_5row: RTL and testbench
===================================

LINE_BUFFER_5ROW -- requirements
Module: line_buffer_5row

Interface
REQ-001 The block SHALL have parameter COLORDEPTH, default 8, meaning pixel width in bits.
REQ-002 The block SHALL have parameter SCREENWIDTH, default 1600, meaning the maximum active pixels per line and the depth of each line memory.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports:
clk  in  1  sole clock, rising edge
rst  in  1  asynchronous active-high reset
px_i  in  COLORDEPTH  raster pixel, valid when dv_i=1
dv_i  in  1  data valid
hs_i  in  1  horizontal sync
vs_i  in  1  vertical sync, active high
vect_o_0  out  COLORDEPTH  current-row pixel
vect_o_1  out  COLORDEPTH  same column, 1 line earlier
vect_o_2  out  COLORDEPTH  same column, 2 lines earlier
vect_o_3  out  COLORDEPTH  same column, 3 lines earlier
vect_o_4  out  COLORDEPTH  same column, 4 lines earlier
dv_o  out  1  dv_i delayed to align with vect_o_*
hs_o  out  1  hs_i delayed to align with vect_o_*
vs_o  out  1  vs_i delayed to align with vect_o_*
lines_o  out  3  valid history rows, 0..4, saturating

Function
REQ-004 The block SHALL contain four line memories of SCREENWIDTH x COLORDEPTH, single write port, synchronous read.
REQ-005 Column counter col SHALL increment on every cycle with dv_i=1, clear on dv_i falling edge (line end), and saturate at SCREENWIDTH-1; pixels beyond SCREENWIDTH SHALL NOT be written.
REQ-006 On a dv_i=1 cycle the block SHALL read address col from all four memories and write px_i into memory wr_sel at col, read-before-write (old content returned).
REQ-007 Write pointer wr_sel SHALL advance by 1 at each line end, wrapping 3->0; memory k lines older SHALL be selected as (wr_sel - k) mod 4.
REQ-008 Outputs vect_o_0..4, dv_o, hs_o, vs_o SHALL be registered with exactly 1 cycle latency from the px_i/dv_i/hs_i/vs_i sample.
REQ-009 vect_o_0 SHALL equal px_i of the previous cycle; vect_o_k (k=1..4) SHALL equal the pixel at the same column written k lines earlier.
REQ-010 Line counter lines_o SHALL increment at each line end, saturate at 4, and clear on vs_i rising edge.
REQ-011 On vs_i rising edge, wr_sel and col SHALL clear to 0; if a line end coincides, clear SHALL win and no increment SHALL occur.
REQ-012 When dv_i=0, vect_o_* SHALL hold 0.
REQ-013 A line end with no preceding dv_i=1 cycle in the line SHALL NOT exist by construction (falling edge requires a prior high); hs_i SHALL NOT affect col or wr_sel.

Reset
REQ-014 While rst=1, all outputs, col, wr_sel, lines_o and delay registers SHALL be 0 asynchronously; memory contents SHALL be unspecified.
REQ-015 Reset asserted mid-line SHALL abort the line; the first line after release SHALL be treated as row 0 of history (lines_o=0).

Configuration
REQ-016 With macro LINE_BUFFER_ZEROPAD_EN defined, vect_o_k (k=1..4) SHALL output 0 whenever k > lines_o (top-border zero padding).
REQ-017 Without LINE_BUFFER_ZEROPAD_EN, vect_o_k SHALL output raw memory content regardless of lines_o.

Verification (SCREENWIDTH=8, COLORDEPTH=8, ZEROPAD enabled unless stated)
REQ-018 Reset release, vs_i pulse, 6 lines of 8 pixels, value = 16*line+col -> on line 5 col 3, vect_o_0..4 = 0x53,0x43,0x33,0x23,0x13, one cycle after input.
REQ-019 Same stream, line 2 col 0 -> vect_o_0..4 = 0x20,0x10,0x00,0,0; lines_o=2.
REQ-020 Line of 10 pixels (overflow) then normal line -> next line's vect_o_1 cols 0..7 match first 8 pixels; col saturates, no wrap into col 0.
REQ-021 vs_i rising edge in same cycle as dv_i falling edge after line 3 -> lines_o=0, wr_sel=0; next line vect_o_1..4 = 0.
REQ-022 rst pulsed mid-line 2 -> all outputs 0 immediately (same cycle, asynchronous); after release, first line shows vect_o_1..4 = 0.
REQ-023 ZEROPAD disabled, second frame line 0 -> vect_o_1..4 return previous-frame data, not 0.

Source files
------------

// File: rtl/line_buffer_5row.sv
// Five-row vertical pixel window built from four line memories.
// Define LINE_BUFFER_ZEROPAD_EN to zero history rows not yet filled.
module line_buffer_5row #(
    parameter int COLORDEPTH  = 8,
    parameter int SCREENWIDTH = 1600
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [COLORDEPTH-1:0] px_i,
    input  logic                  dv_i,
    input  logic                  hs_i,
    input  logic                  vs_i,
    output logic [COLORDEPTH-1:0] vect_o_0,
    output logic [COLORDEPTH-1:0] vect_o_1,
    output logic [COLORDEPTH-1:0] vect_o_2,
    output logic [COLORDEPTH-1:0] vect_o_3,
    output logic [COLORDEPTH-1:0] vect_o_4,
    output logic                  dv_o,
    output logic                  hs_o,
    output logic                  vs_o,
    output logic [2:0]            lines_o
);

    localparam int CW = (SCREENWIDTH > 1) ? $clog2(SCREENWIDTH) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(SCREENWIDTH - 1);

    logic [CW-1:0]         col;
    logic                  ovf;
    logic [1:0]            wr_sel;
    logic [1:0]            sel_q;
    logic [2:0]            lines;
    logic                  dv_q;
    logic                  hs_q;
    logic                  vs_q;
    logic [COLORDEPTH-1:0] px_q;
    logic                  line_end;
    logic                  vs_rise;
    logic                  wr_en;

    logic [3:0][COLORDEPTH-1:0] rd;
    logic [COLORDEPTH-1:0]      hist [1:4];

    assign line_end = dv_q & ~dv_i;
    assign vs_rise  = vs_i & ~vs_q;
    // ovf marks that the last column was already written this line
    assign wr_en    = dv_i & ~ovf;

    for (genvar m = 0; m < 4; m++) begin : g_mem
        logic [COLORDEPTH-1:0] ram [SCREENWIDTH];
        logic [COLORDEPTH-1:0] q;

        always_ff @(posedge clk) begin
            if (dv_i)
                q <= ram[col];
            if (wr_en && wr_sel == 2'(m))
                ram[col] <= px_i;
        end

        assign rd[m] = q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col    <= '0;
            ovf    <= 1'b0;
            wr_sel <= '0;
            sel_q  <= '0;
            lines  <= '0;
            dv_q   <= 1'b0;
            hs_q   <= 1'b0;
            vs_q   <= 1'b0;
            px_q   <= '0;
        end else begin
            dv_q  <= dv_i;
            hs_q  <= hs_i;
            vs_q  <= vs_i;
            sel_q <= wr_sel;
            px_q  <= dv_i ? px_i : '0;
            // frame start overrides a coincident line end
            if (vs_rise) begin
                col    <= '0;
                ovf    <= 1'b0;
                wr_sel <= '0;
                lines  <= '0;
            end else if (line_end) begin
                col    <= '0;
                ovf    <= 1'b0;
                wr_sel <= wr_sel + 2'd1;
                if (lines != 3'd4)
                    lines <= lines + 3'd1;
            end else if (dv_i) begin
                if (col == COL_MAX)
                    ovf <= 1'b1;
                else
                    col <= col + CW'(1);
            end
        end
    end

    always_comb begin
        for (int k = 1; k <= 4; k++) begin
            hist[k] = '0;
`ifdef LINE_BUFFER_ZEROPAD_EN
            if (dv_q && 3'(k) <= lines)
                hist[k] = rd[sel_q - 2'(k)];
`else
            if (dv_q)
                hist[k] = rd[sel_q - 2'(k)];
`endif
        end
    end

    assign vect_o_0 = px_q;
    assign vect_o_1 = hist[1];
    assign vect_o_2 = hist[2];
    assign vect_o_3 = hist[3];
    assign vect_o_4 = hist[4];
    assign dv_o     = dv_q;
    assign hs_o     = hs_q;
    assign vs_o     = vs_q;
    assign lines_o  = lines;

endmodule

// File: tb/tb_line_buffer_5row.sv
// Directed bench for line_buffer_5row with an 8-pixel line.
// Expectations follow LINE_BUFFER_ZEROPAD_EN when it is defined.
module tb_line_buffer_5row;

`ifdef LINE_BUFFER_ZEROPAD_EN
    localparam bit ZP = 1'b1;
`else
    localparam bit ZP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] px_i;
    logic       dv_i;
    logic       hs_i;
    logic       vs_i;
    logic [7:0] vect_o_0, vect_o_1, vect_o_2, vect_o_3, vect_o_4;
    logic       dv_o, hs_o, vs_o;
    logic [2:0] lines_o;

    int nvec = 0;
    int nbad = 0;

    always #5 clk = ~clk;

    line_buffer_5row #(.COLORDEPTH(8), .SCREENWIDTH(8)) dut (
        .clk(clk), .rst(rst), .px_i(px_i), .dv_i(dv_i),
        .hs_i(hs_i), .vs_i(vs_i),
        .vect_o_0(vect_o_0), .vect_o_1(vect_o_1), .vect_o_2(vect_o_2),
        .vect_o_3(vect_o_3), .vect_o_4(vect_o_4),
        .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o), .lines_o(lines_o)
    );

    typedef struct packed {
        logic [7:0]      px;
        logic            dv;
        logic            hs;
        logic            vs;
        logic [4:0][7:0] e;
        logic [4:0]      m;
        logic [2:0]      el;
    } vec_t;

    vec_t tbl [$];

    function automatic logic [7:0] vout(input int k);
        case (k)
            0: vout = vect_o_0;
            1: vout = vect_o_1;
            2: vout = vect_o_2;
            3: vout = vect_o_3;
            default: vout = vect_o_4;
        endcase
    endfunction

    function automatic vec_t mkv(input logic [7:0] px, input logic dv,
                                 input logic hs, input logic vs,
                                 input int el);
        vec_t v;
        v.px = px;
        v.dv = dv;
        v.hs = hs;
        v.vs = vs;
        v.e  = '0;
        v.m  = 5'h1f;
        v.el = (el > 4) ? 3'd4 : 3'(el);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic step(input logic [7:0] px, input logic dv,
                        input logic hs, input logic vs);
        px_i = px;
        dv_i = dv;
        hs_i = hs;
        vs_i = vs;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string nm);
        for (int k = 0; k < 5; k++)
            chk($sformatf("%s v%0d", nm, k), 32'(vout(k)), 0);
        chk({nm, " dv"}, 32'(dv_o), 0);
        chk({nm, " hs"}, 32'(hs_o), 0);
        chk({nm, " vs"}, 32'(vs_o), 0);
        chk({nm, " lines"}, 32'(lines_o), 0);
    endtask

    initial begin
        vec_t v;

        // frame 1: six lines, pixel = 16*line + col
        tbl.push_back(mkv(8'h00, 1'b0, 1'b0, 1'b1, 0));
        tbl.push_back(mkv(8'h00, 1'b0, 1'b0, 1'b0, 0));
        for (int l = 0; l < 6; l++) begin
            for (int c = 0; c < 8; c++) begin
                v = mkv(8'(16 * l + c), 1'b1, 1'b0, 1'b0, l);
                v.e[0] = v.px;
                for (int k = 1; k <= 4; k++) begin
                    if (l >= k)
                        v.e[k] = 8'(16 * (l - k) + c);
                    else if (!ZP)
                        v.m[k] = 1'b0;
                end
                tbl.push_back(v);
            end
            tbl.push_back(mkv(8'h00, 1'b0, 1'b1, 1'b0, l + 1));
        end
        // frame 2 line 0: history is last frame's data unless padded
        tbl.push_back(mkv(8'h00, 1'b0, 1'b0, 1'b1, 0));
        tbl.push_back(mkv(8'h00, 1'b0, 1'b0, 1'b0, 0));
        for (int c = 0; c < 8; c++) begin
            v = mkv(8'(8'hE0 + c), 1'b1, 1'b0, 1'b0, 0);
            v.e[0] = v.px;
            if (!ZP) begin
                v.e[1] = 8'(8'h30 + c);
                v.e[2] = 8'(8'h20 + c);
                v.e[3] = 8'(8'h50 + c);
                v.e[4] = 8'(8'h40 + c);
            end
            tbl.push_back(v);
        end
        tbl.push_back(mkv(8'h00, 1'b0, 1'b1, 1'b0, 1));

        rst  = 1'b1;
        px_i = '0;
        dv_i = 1'b0;
        hs_i = 1'b0;
        vs_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].px, tbl[i].dv, tbl[i].hs, tbl[i].vs);
            for (int k = 0; k < 5; k++)
                if (tbl[i].m[k])
                    chk($sformatf("t%0d v%0d", i, k),
                        32'(vout(k)), 32'(tbl[i].e[k]));
            chk($sformatf("t%0d dv", i), 32'(dv_o), 32'(tbl[i].dv));
            chk($sformatf("t%0d hs", i), 32'(hs_o), 32'(tbl[i].hs));
            chk($sformatf("t%0d vs", i), 32'(vs_o), 32'(tbl[i].vs));
            chk($sformatf("t%0d lines", i), 32'(lines_o), 32'(tbl[i].el));
        end

        // overflow: 10 pixels then a normal line reading them back
        step(8'h00, 1'b0, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(8'(8'hA0 + i), 1'b1, 1'b0, 1'b0);
            chk($sformatf("ovf v0[%0d]", i), 32'(vect_o_0), 32'(8'hA0 + i));
        end
        step(8'h00, 1'b0, 1'b0, 1'b0);
        chk("ovf lines", 32'(lines_o), 1);
        for (int c = 0; c < 8; c++) begin
            step(8'(8'hB0 + c), 1'b1, 1'b0, 1'b0);
            chk($sformatf("ovf v1[%0d]", c), 32'(vect_o_1), 32'(8'hA0 + c));
        end
        step(8'h00, 1'b0, 1'b0, 1'b0);

        // frame start on the same cycle as the third line end
        step(8'h00, 1'b0, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b0, 1'b0);
        for (int l = 0; l < 3; l++) begin
            for (int c = 0; c < 8; c++)
                step(8'(8'h70 + 16 * l + c), 1'b1, 1'b0, 1'b0);
            if (l < 2)
                step(8'h00, 1'b0, 1'b0, 1'b0);
        end
        step(8'h00, 1'b0, 1'b0, 1'b1);
        chk("coin lines", 32'(lines_o), 0);
        step(8'h00, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 8; c++) begin
            step(8'(8'hC0 + c), 1'b1, 1'b0, 1'b0);
            chk($sformatf("coin lines[%0d]", c), 32'(lines_o), 0);
            chk($sformatf("coin v2[%0d]", c), 32'(vect_o_2),
                ZP ? 0 : 32'(8'h90 + c));
            chk($sformatf("coin v3[%0d]", c), 32'(vect_o_3),
                ZP ? 0 : 32'(8'h80 + c));
            chk($sformatf("coin v4[%0d]", c), 32'(vect_o_4),
                ZP ? 0 : 32'(8'h70 + c));
`ifdef LINE_BUFFER_ZEROPAD_EN
            chk($sformatf("coin v1[%0d]", c), 32'(vect_o_1), 0);
`endif
        end
        step(8'h00, 1'b0, 1'b0, 1'b0);
        chk("coin end lines", 32'(lines_o), 1);

        // asynchronous reset in the middle of line 2
        step(8'h00, 1'b0, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b0, 1'b0);
        for (int l = 0; l < 2; l++) begin
            for (int c = 0; c < 8; c++)
                step(8'(8'h10 * l + 8'h05 + c), 1'b1, 1'b1, 1'b0);
            step(8'h00, 1'b0, 1'b0, 1'b0);
        end
        for (int c = 0; c < 3; c++)
            step(8'(8'h25 + c), 1'b1, 1'b1, 1'b0);
        chk("pre-rst dv", 32'(dv_o), 1);
        chk("pre-rst lines", 32'(lines_o), 2);
        #2 rst = 1'b1;
        #1;
        chk_zero("async rst");
        @(posedge clk);
        #1;
        chk_zero("held rst");
        rst = 1'b0;
        step(8'h00, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 8; c++) begin
            step(8'(8'hD0 + c), 1'b1, 1'b0, 1'b0);
            chk($sformatf("post-rst v0[%0d]", c), 32'(vect_o_0),
                32'(8'hD0 + c));
            chk($sformatf("post-rst lines[%0d]", c), 32'(lines_o), 0);
`ifdef LINE_BUFFER_ZEROPAD_EN
            for (int k = 1; k <= 4; k++)
                chk($sformatf("post-rst v%0d[%0d]", k, c), 32'(vout(k)), 0);
`endif
        end
        step(8'h00, 1'b0, 1'b0, 1'b0);
        chk("post-rst end lines", 32'(lines_o), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
